// File: rtl/riscv_br_pkg.sv
// Shared RV32I control-transfer encodings and 2-bit predictor counter helpers
// for the EX-stage branch resolver.
package riscv_br_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic [1:0] {
    CT_NONE,
    CT_BRANCH,
    CT_JAL,
    CT_JALR
  } ctrl_kind_e;

  // Saturating step: never wraps between strongly-taken and strongly-not-taken.
  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == ST) ? ST : cnt + 2'b01;
    end
    return (cnt == SNT) ? SNT : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle of the fetch-lookup and EX-resolve signals of the branch resolver;
// master drives the pipeline side, slave is the resolver.
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);

  logic [XLEN-1:0]  if_pc;
  logic             if_pred_taken;
  logic             ex_valid;
  logic [31:0]      ex_ir;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_a;
  logic [XLEN-1:0]  ex_b;
  logic [XLEN-1:0]  ex_imm;
  logic             ex_pred_taken;
  logic             redirect;
  logic [XLEN-1:0]  next_pc;
  logic [XLEN-1:0]  link_addr;
  logic             misalign;
  logic [CNT_W-1:0] perf_branches;
  logic [CNT_W-1:0] perf_mispredicts;

  modport master (
    output if_pc, ex_valid, ex_ir, ex_pc, ex_a, ex_b, ex_imm, ex_pred_taken,
    input  if_pred_taken, redirect, next_pc, link_addr, misalign,
           perf_branches, perf_mispredicts
  );

  modport slave (
    input  if_pc, ex_valid, ex_ir, ex_pc, ex_a, ex_b, ex_imm, ex_pred_taken,
    output if_pred_taken, redirect, next_pc, link_addr, misalign,
           perf_branches, perf_mispredicts
  );

endinterface

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating branch counters: asynchronous lookup port for IF,
// synchronous training port for EX. Reset leaves every entry weakly not-taken.
module bht_2bit
  import riscv_br_pkg::*;
#(
  parameter int BHT_DEPTH = 64,
  localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [BHT_DEPTH-1:0][1:0] cnt_q;
  logic [BHT_DEPTH-1:0][1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (upd_en) begin
      cnt_d[upd_idx] = bht_next(cnt_q[upd_idx], upd_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {BHT_DEPTH{WNT}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Reads the registered table, so a same-cycle update is not visible yet.
  assign rd_taken = cnt_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage resolver for RV32I branches and jumps: compares, computes targets,
// checks IF's prediction and emits registered redirect/misalign/link results.
module branch_resolve_unit
  import riscv_br_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  ctrl_kind_e       kind;
  logic             legal_br;
  logic             br_cond;
  logic             taken;
  logic             bad_align;
  logic             want_redirect;
  logic             bht_upd;
  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  pc_target;
  logic [XLEN-1:0]  jalr_target;
  logic [XLEN-1:0]  target;

  logic             redirect_q, redirect_d;
  logic             misalign_q, misalign_d;
  logic [XLEN-1:0]  next_pc_q, next_pc_d;
  logic [XLEN-1:0]  link_addr_q, link_addr_d;
  logic [CNT_W-1:0] perf_br_q, perf_br_d;
  logic [CNT_W-1:0] perf_mp_q, perf_mp_d;

  logic             unused_bits;

  assign opcode = bus.ex_ir[6:0];
  assign funct3 = bus.ex_ir[14:12];

  always_comb begin
    unique case (opcode)
      OP_BRANCH: kind = CT_BRANCH;
      OP_JAL:    kind = CT_JAL;
      OP_JALR:   kind = CT_JALR;
      default:   kind = CT_NONE;
    endcase
  end

  always_comb begin
    legal_br = 1'b1;
    br_cond  = 1'b0;
    unique case (funct3)
      F3_BEQ:  br_cond = (bus.ex_a == bus.ex_b);
      F3_BNE:  br_cond = (bus.ex_a != bus.ex_b);
      F3_BLT:  br_cond = ($signed(bus.ex_a) <  $signed(bus.ex_b));
      F3_BGE:  br_cond = ($signed(bus.ex_a) >= $signed(bus.ex_b));
      F3_BLTU: br_cond = (bus.ex_a <  bus.ex_b);
      F3_BGEU: br_cond = (bus.ex_a >= bus.ex_b);
      default: legal_br = 1'b0;
    endcase
  end

  assign seq_pc      = bus.ex_pc + XLEN'(4);
  assign pc_target   = bus.ex_pc + bus.ex_imm;
  assign jalr_target = (bus.ex_a + bus.ex_imm) & ~XLEN'(1);

  always_comb begin
    taken         = 1'b0;
    target        = pc_target;
    want_redirect = 1'b0;
    unique case (kind)
      CT_BRANCH: begin
        // Unknown funct3 behaves as a not-taken branch for prediction purposes.
        taken         = legal_br & br_cond;
        want_redirect = (taken != bus.ex_pred_taken);
      end
      CT_JAL: begin
        taken         = 1'b1;
        want_redirect = 1'b1;
      end
      CT_JALR: begin
        taken         = 1'b1;
        target        = jalr_target;
        want_redirect = 1'b1;
      end
      default: ;
    endcase
  end

  // A misaligned target is handed to the trap logic instead of redirecting.
  assign bad_align = taken & target[1];
  assign bht_upd   = bus.ex_valid & (kind == CT_BRANCH) & legal_br;

  always_comb begin
    misalign_d  = bus.ex_valid & bad_align;
    redirect_d  = bus.ex_valid & want_redirect & ~bad_align;
    next_pc_d   = next_pc_q;
    link_addr_d = link_addr_q;
    if (redirect_d) begin
      next_pc_d = taken ? target : seq_pc;
    end
    if (bus.ex_valid && (kind == CT_JAL || kind == CT_JALR)) begin
      link_addr_d = seq_pc;
    end
    perf_br_d = perf_br_q + CNT_W'(bht_upd);
    perf_mp_d = perf_mp_q + CNT_W'(redirect_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_q  <= 1'b0;
      misalign_q  <= 1'b0;
      next_pc_q   <= '0;
      link_addr_q <= '0;
      perf_br_q   <= '0;
      perf_mp_q   <= '0;
    end else begin
      redirect_q  <= redirect_d;
      misalign_q  <= misalign_d;
      next_pc_q   <= next_pc_d;
      link_addr_q <= link_addr_d;
      perf_br_q   <= perf_br_d;
      perf_mp_q   <= perf_mp_d;
    end
  end

  bht_2bit #(
    .BHT_DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (bus.if_pc[IDX_W+1:2]),
    .rd_taken  (bus.if_pred_taken),
    .upd_en    (bht_upd),
    .upd_idx   (bus.ex_pc[IDX_W+1:2]),
    .upd_taken (taken)
  );

  assign bus.redirect         = redirect_q;
  assign bus.misalign         = misalign_q;
  assign bus.next_pc          = next_pc_q;
  assign bus.link_addr        = link_addr_q;
  assign bus.perf_branches    = perf_br_q;
  assign bus.perf_mispredicts = perf_mp_q;

  assign unused_bits = ^{bus.ex_ir[31:15], bus.ex_ir[11:7],
                         bus.if_pc[1:0], bus.if_pc[XLEN-1:IDX_W+2]};

endmodule
